// File: rtl/fibo_arb_pkg.sv
// fibo_arbiter shared types and constants.
// Two requesters share one fibonacci generator.
package fibo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int MAX_FIBO   = 46368;
  localparam int DEF_LEN_W  = 4;
  localparam int DEF_DATA_W = 16;

endpackage

// File: rtl/fibo_arb_if.sv
// Consumer-side bundle of fibo_arbiter:
// requests/lengths in, tagged terms out.
interface fibo_arb_if
  import fibo_arb_pkg::*;
#(
  parameter int LEN_W  = DEF_LEN_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              req0;
  logic              req1;
  logic [LEN_W-1:0]  len0;
  logic [LEN_W-1:0]  len1;
  logic              done0;
  logic              done1;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_id;
  logic              out_last;

  modport master (
    output req0, req1, len0, len1,
    input  done0, done1, out_valid,
    input  out_data, out_id, out_last
  );

  modport slave (
    input  req0, req1, len0, len1,
    output done0, done1, out_valid,
    output out_data, out_id, out_last
  );

endinterface

// File: rtl/fibo_rr_pick.sv
// Two-way round-robin pick: on a tie the
// requester not granted last wins.
module fibo_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_id,
  output logic grant_valid,
  output logic grant_id
);

  assign grant_valid = req0 | req1;
  assign grant_id    = (req0 & req1) ? ~last_id : req1;

endmodule

// File: rtl/fibonacci.sv
// Fibonacci term generator: each enabled edge
// loads the next term, wrapping to 0 after MAX_FIBO.
module fibonacci
  import fibo_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              f_en,
  output logic [DATA_W-1:0] f_out
);

  logic [DATA_W-1:0] f_q, f_d;
  logic [DATA_W-1:0] n_q, n_d;
  logic [DATA_W-1:0] m_q, m_d;

  // n_q is the term to emit next, m_q the one after it
  always_comb begin
    f_d = f_q;
    n_d = n_q;
    m_d = m_q;
    if (f_en) begin
      f_d = n_q;
      if (n_q == DATA_W'(MAX_FIBO)) begin
        n_d = '0;
        m_d = DATA_W'(1);
      end else begin
        n_d = m_q;
        m_d = n_q + m_q;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      f_q <= '0;
      n_q <= '0;
      m_q <= DATA_W'(1);
    end else begin
      f_q <= f_d;
      n_q <= n_d;
      m_q <= m_d;
    end
  end

  assign f_out = f_q;

endmodule

// File: rtl/fibo_arbiter.sv
// Grants the shared generator to one of two
// requesters for a 1..2^LEN_W term burst.
module fibo_arbiter
  import fibo_arb_pkg::*;
#(
  parameter int LEN_W  = DEF_LEN_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  fibo_arb_if.slave         bus,
  output logic              gen_en,
  input  logic [DATA_W-1:0] gen_out,
  output logic              busy
);

  state_e           state_q, state_d;
  logic [LEN_W:0]   cnt_q, cnt_d;
  logic             id_q, id_d;
  logic             last_id_q, last_id_d;
  logic             gen_en_q, gen_en_d;
  logic             ov_q, ov_d;
  logic             oid_q, oid_d;
  logic             olast_q, olast_d;
  logic             grant_valid;
  logic             grant_id;
  logic [LEN_W-1:0] lsel;

  fibo_rr_pick u_pick (
    .req0        (bus.req0),
    .req1        (bus.req1),
    .last_id     (last_id_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign lsel = grant_id ? bus.len1 : bus.len0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    last_id_d = last_id_q;
    gen_en_d  = 1'b0;
    ov_d      = gen_en_q;
    oid_d     = gen_en_q & id_q;
    olast_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d   = RUN;
          id_d      = grant_id;
          last_id_d = grant_id;
          // a zero length selects the full 2^LEN_W burst
          cnt_d     = {(lsel == '0), lsel};
          gen_en_d  = 1'b1;
        end
      end
      RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q > (LEN_W+1)'(1)) begin
          gen_en_d = 1'b1;
        end else begin
          olast_d = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      id_q      <= 1'b0;
      last_id_q <= 1'b1;
      gen_en_q  <= 1'b0;
      ov_q      <= 1'b0;
      oid_q     <= 1'b0;
      olast_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      last_id_q <= last_id_d;
      gen_en_q  <= gen_en_d;
      ov_q      <= ov_d;
      oid_q     <= oid_d;
      olast_q   <= olast_d;
    end
  end

  assign gen_en        = gen_en_q;
  assign busy          = (state_q != IDLE);
  assign bus.out_valid = ov_q;
  assign bus.out_data  = ov_q ? gen_out : '0;
  assign bus.out_id    = oid_q;
  assign bus.out_last  = olast_q;
  assign bus.done0     = olast_q & ~oid_q;
  assign bus.done1     = olast_q & oid_q;

endmodule

// File: doc/fibo_arbiter.md
# fibo_arbiter

Shares one `fibonacci` generator between two requesters. Each requester asks for a burst of 1–16 consecutive terms. The block grants requesters round-robin, drives the generator enable for exactly the burst length, and returns every term tagged with the owner id plus a last-term flag. It sits between the generator and the two consumer ports in the same clock domain as the generator.

## Interface
- `LEN_W`, default 4: width of burst-length inputs; a value of 0 means 2^LEN_W terms.
- `DATA_W`, default 16: term width; must match the generator output.
- `clock` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high. Also wired to the generator reset.
- `req0`, `req1` input 1: burst request. Held high until the matching `done` pulse.
- `len0`, `len1` input LEN_W: burst length. Sampled only in the grant cycle.
- `done0`, `done1` output 1: one-cycle pulse with the final term of that requester's burst.
- `gen_en` output 1: registered enable to the generator `f_en`.
- `gen_out` input DATA_W: generator `f_out`.
- `out_valid` output 1: `out_data` holds a term this cycle.
- `out_data` output DATA_W: the term.
- `out_id` output 1: owner of the term (0/1).
- `out_last` output 1: final term of the burst.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- **Generator contract:**
  - Each clock edge with `f_en`=1 loads `gen_out` with the next term of 0,1,1,2,3,5,…,46368.
  - The sequence then wraps to 0.
- **Sequence continuity:**
  - The sequence is not restarted per grant.
  - Consecutive bursts continue where the previous burst stopped, regardless of requester.
- **FSM states:**
  - IDLE → RUN on grant.
  - RUN → DRAIN when the remaining count reaches 0 after the last enable.
  - DRAIN → IDLE unconditionally after 1 cycle.
- **Grant rules (IDLE only):**
  - Only one request high: grant that requester.
  - Both high: grant the requester not granted last.
  - Pointer `last_id` updates on each grant. After reset it makes requester 0 win the first tie.
- **Grant cycle:**
  - Latch `cnt` = len of the granted requester (0 → 2^LEN_W).
  - Latch `id`.
  - Set `gen_en`.
- **RUN:**
  - `gen_en` stays 1 while `cnt`>1; `cnt` decrements each cycle.
  - `gen_en` drops after exactly `cnt` cycles high.
- **Output path:**
  - `out_valid` is `gen_en` delayed one cycle.
  - `out_data` = `gen_out` and `out_id` = `id` in that cycle.
  - `out_last` = `out_valid` on the final term.
  - `done<id>` = `out_last` for the owning requester; the other `done` stays 0.
- **Requests:**
  - A request arriving during RUN/DRAIN waits; it is never dropped.
  - `req` deasserted before grant is simply not served.
- **Out-of-contract:** `len` changing after grant has no effect.

## Timing
- **Reset values:**
  - All outputs are 0.
  - State IDLE, `cnt`=0, `last_id`=1 (requester 0 has priority).
- **Burst of L terms, request sampled in IDLE at cycle T0:**
  - `gen_en`=1 in T1..TL.
  - `out_valid`=1 in T2..T(L+1).
  - `out_last`/`done` in T(L+1); state DRAIN in T(L+1).
  - IDLE in T(L+2), when the next grant may be sampled.
- **Latencies:**
  - Request to first term: 2 cycles.
  - Back-to-back bursts: 2 idle cycles between last term and next first term.
- **Requester handshake:** a requester that registers `done` deasserts `req` by T(L+2), so it is not re-granted.
- **Wrap-around:** a burst spanning 46368 delivers …,28657,46368,0,1,… with no gap.
- **Reset mid-burst:**
  - All outputs drop immediately (asynchronous).
  - No `done` is issued.
  - The generator restarts at 0.

## Structure
- **Package `fibo_arb_pkg`:**
  - State enum (IDLE, RUN, DRAIN).
  - `MAX_FIBO` = 46368.
  - Default `LEN_W`/`DATA_W`.
- **Sub-module `fibo_rr_pick`:**
  - Combinational 2-way round-robin selector.
  - Inputs `req0`/`req1`/`last_id`; outputs `grant_valid` and `grant_id`.
- FSM, counter and output registers live in `fibo_arbiter`.
- The bench top instantiates `fibo_arbiter` together with `fibonacci`.

## Test plan
- **Single burst, req0:**
  - Stimulus: reset, then `req0`=1, `len0`=5.
  - Response: `out_data` 0,1,1,2,3 with `out_id`=0; `out_last`/`done0` on term 3.
  - Check: first term 2 cycles after request sampled.
- **Tie after reset:**
  - Stimulus: `req0`=`req1`=1, lengths 2/3.
  - Response: id0 gets 0,1, then id1 gets 1,2,3.
  - Check: 2-cycle gap between bursts.
- **Fairness:** `req0` and `req1` held continuously for 4 bursts → grants alternate 0,1,0,1.
- **Len 0:** `len1`=0 → exactly 16 terms, 0…610, then `done1`.
- **Wrap:** drive bursts totalling 26 terms → term 24 = 46368, term 25 = 0, no gap inside the burst.
- **Reset mid-burst:**
  - Stimulus: assert `reset` at the 3rd `gen_en` cycle.
  - Response: outputs 0 immediately, no `done`.
  - Check: the next burst starts at term 0.
